// File: rtl/ifetch_buf.sv
// Sequential instruction fetch into a small FIFO with redirect/flush and request timeout.
// Optional IFETCH_BYPASS_EN: ack data reaches the head combinationally when the FIFO is empty.
module ifetch_buf #(
   parameter int                ADDR_W   = 64,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                MAX_WAIT = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       mem_req,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic                       mem_ack,
   input  logic [63:0]                mem_rdata,
   output logic                       instr_valid,
   output logic [31:0]                instr,
   output logic [ADDR_W-1:0]          instr_pc,
   input  logic                       instr_ready,
   output logic                       fetch_err,
   output logic [$clog2(DEPTH+1)-1:0] buf_count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int WW = $clog2(MAX_WAIT+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT-1);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DISC = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   logic [1:0]                    state;
   logic [ADDR_W-1:0]             fetch_pc;
   logic [WW-1:0]                 wait_cnt;
   logic [DEPTH-1:0][31:0]        fifo_ins;
   logic [DEPTH-1:0][ADDR_W-1:0]  fifo_pc;
   logic [PW-1:0]                 rd_ptr, wr_ptr;
   logic [CW-1:0]                 count, cnt_nxt;
   logic                          head_vld, acc, push, pop, slot_free, timeout, busy;
   logic                          unused_rdata;

   assign unused_rdata = ^mem_rdata[31:0];
   assign head_vld     = (count != '0);
   assign acc          = (state == ST_WAIT) && mem_ack && !redirect;
   assign pop          = head_vld && instr_ready;
   assign timeout      = (wait_cnt >= WAIT_LAST);
   assign busy         = (state == ST_WAIT) || (state == ST_DISC);

`ifdef IFETCH_BYPASS_EN
   logic byp;
   assign byp         = acc && !head_vld;
   assign instr_valid = head_vld || byp;
   assign instr       = byp ? mem_rdata[63:32] : fifo_ins[rd_ptr];
   assign instr_pc    = byp ? mem_addr : fifo_pc[rd_ptr];
   // a bypassed word taken this cycle never occupies a slot
   assign push        = acc && !(byp && instr_ready);
`else
   assign instr_valid = head_vld;
   assign instr       = fifo_ins[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];
   assign push        = acc;
`endif

   always_comb begin
      cnt_nxt   = count + CW'(push) - CW'(pop);
      slot_free = (cnt_nxt < DEPTH_C);
   end

   assign buf_count = count;

   // Fetch control: fetch_pc is always the address of the next (or outstanding) request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_RUN;
         fetch_pc  <= RESET_PC;
         mem_req   <= 1'b0;
         mem_addr  <= RESET_PC;
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
      end else if (redirect) begin
         fetch_pc  <= {redirect_pc[ADDR_W-1:2], 2'b00};
         fetch_err <= 1'b0;
         if (busy && !mem_ack) begin
            // bus request cannot be withdrawn; let it finish, then drop its data
            state <= ST_DISC;
            if (!timeout) wait_cnt <= wait_cnt + WW'(1);
         end else begin
            state    <= ST_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= {redirect_pc[ADDR_W-1:2], 2'b00};
            wait_cnt <= '0;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (slot_free) begin
                  state    <= ST_WAIT;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  fetch_pc <= fetch_pc + ADDR_W'(4);
                  wait_cnt <= '0;
                  if (slot_free) begin
                     mem_addr <= fetch_pc + ADDR_W'(4);
                  end else begin
                     mem_req <= 1'b0;
                     state   <= ST_RUN;
                  end
               end else if (timeout) begin
                  mem_req   <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= ST_HALT;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            ST_DISC: begin
               if (mem_ack) begin
                  mem_addr <= fetch_pc;
                  wait_cnt <= '0;
                  state    <= ST_WAIT;
               end else if (timeout) begin
                  mem_req   <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= ST_HALT;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_ins <= '0;
         fifo_pc  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_ins[wr_ptr] <= mem_rdata[63:32];
            fifo_pc[wr_ptr]  <= mem_addr;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= cnt_nxt;
      end
   end
endmodule
